// File: rtl/demux_pkg.sv
// Shared defaults and slot state encoding for the demux_buf block.
package demux_pkg;

    localparam int DEMUX_WIDTH_DEF = 32;
    localparam int DEMUX_CNT_W_DEF = 16;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_state_e;

endpackage

// File: rtl/demux_slot.sv
// One-word holding register for a demux_buf output channel.
module demux_slot
    import demux_pkg::*;
#(
    parameter int WIDTH = DEMUX_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             drain,
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] q,
    output logic             valid,
    output logic             can_load
);

    slot_state_e      r_state;
    slot_state_e      w_state_nxt;
    logic [WIDTH-1:0] r_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            EMPTY: if (load) w_state_nxt = FULL;
            FULL:  if (drain && !load) w_state_nxt = EMPTY;
            default: w_state_nxt = EMPTY;
        endcase
    end

    // Data is kept after a drain; only a load replaces it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_q <= '0;
        end else if (load) begin
            r_q <= data;
        end
    end

    assign q        = r_q;
    assign valid    = (r_state == FULL);
    assign can_load = (r_state == EMPTY) || drain;

endmodule

// File: rtl/demux_buf.sv
// Two-channel registered demultiplexer with one-word slot per channel.
// Optional per-channel delivery counters are enabled by DEMUX_BUF_COUNT_EN.
module demux_buf
    import demux_pkg::*;
#(
    parameter int WIDTH = DEMUX_WIDTH_DEF,
    parameter int CNT_W = DEMUX_CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    input  logic             sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] qa,
    output logic             qa_valid,
    input  logic             qa_ready,
    output logic [WIDTH-1:0] qb,
    output logic             qb_valid,
    input  logic             qb_ready
`ifdef DEMUX_BUF_COUNT_EN
    ,
    output logic [CNT_W-1:0] cnt_a,
    output logic [CNT_W-1:0] cnt_b
`endif
);

    logic w_can_a;
    logic w_can_b;
    logic w_xfer;
    logic w_load_a;
    logic w_load_b;

    if (CNT_W < 1) begin : g_cnt_w_check
        $error("demux_buf: CNT_W must be at least 1");
    end

    assign in_ready = sel ? w_can_b : w_can_a;
    assign w_xfer   = in_valid && in_ready;
    assign w_load_a = w_xfer && !sel;
    assign w_load_b = w_xfer && sel;

    demux_slot #(.WIDTH(WIDTH)) u_slot_a (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (w_load_a),
        .drain    (qa_ready),
        .data     (d),
        .q        (qa),
        .valid    (qa_valid),
        .can_load (w_can_a)
    );

    demux_slot #(.WIDTH(WIDTH)) u_slot_b (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (w_load_b),
        .drain    (qb_ready),
        .data     (d),
        .q        (qb),
        .valid    (qb_valid),
        .can_load (w_can_b)
    );

`ifdef DEMUX_BUF_COUNT_EN
    logic [CNT_W-1:0] r_cnt_a;
    logic [CNT_W-1:0] r_cnt_b;

    // A delivery is a handshake on the output side; counters wrap naturally.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt_a <= '0;
            r_cnt_b <= '0;
        end else begin
            if (qa_valid && qa_ready) r_cnt_a <= r_cnt_a + CNT_W'(1);
            if (qb_valid && qb_ready) r_cnt_b <= r_cnt_b + CNT_W'(1);
        end
    end

    assign cnt_a = r_cnt_a;
    assign cnt_b = r_cnt_b;
`endif

endmodule

// File: tb/tb_demux_buf.sv
// Scoreboard bench for demux_buf: stimulus pushes expected words, a negedge monitor checks deliveries.
module tb_demux_buf;

    localparam int W = 32;
`ifdef DEMUX_BUF_COUNT_EN
    localparam int CW = 2;
`else
    localparam int CW = 16;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] d = '0;
    logic         sel = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] qa, qb;
    logic         qa_valid, qb_valid;
    logic         qa_ready = 1'b0;
    logic         qb_ready = 1'b0;
`ifdef DEMUX_BUF_COUNT_EN
    logic [CW-1:0] cnt_a, cnt_b;
    logic [CW-1:0] exp_cnt_a = '0;
    logic [CW-1:0] exp_cnt_b = '0;
`endif

    int checks = 0;
    int failures = 0;
    logic [W-1:0] exp_a[$];
    logic [W-1:0] exp_b[$];

    demux_buf #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .d        (d),
        .sel      (sel),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .qa       (qa),
        .qa_valid (qa_valid),
        .qa_ready (qa_ready),
        .qb       (qb),
        .qb_valid (qb_valid),
        .qb_ready (qb_ready)
`ifdef DEMUX_BUF_COUNT_EN
        ,
        .cnt_a    (cnt_a),
        .cnt_b    (cnt_b)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: valid must mirror outstanding words; each handshake pops and compares.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("qa_valid", W'(qa_valid), W'(exp_a.size() != 0));
            chk("qb_valid", W'(qb_valid), W'(exp_b.size() != 0));
`ifdef DEMUX_BUF_COUNT_EN
            chk("cnt_a", W'(cnt_a), W'(exp_cnt_a));
            chk("cnt_b", W'(cnt_b), W'(exp_cnt_b));
`endif
            if (qa_valid && qa_ready) begin
                if (exp_a.size() == 0) chk("qa_unexpected", qa, ~qa);
                else chk("qa_data", qa, exp_a.pop_front());
`ifdef DEMUX_BUF_COUNT_EN
                exp_cnt_a = exp_cnt_a + CW'(1);
`endif
            end
            if (qb_valid && qb_ready) begin
                if (exp_b.size() == 0) chk("qb_unexpected", qb, ~qb);
                else chk("qb_data", qb, exp_b.pop_front());
`ifdef DEMUX_BUF_COUNT_EN
                exp_cnt_b = exp_cnt_b + CW'(1);
`endif
            end
        end
    end

    // One cycle: drive inputs, check in_ready, then record an accepted word.
    task automatic step(input logic [W-1:0] vd, input logic vs, input logic vv,
                        input logic ra, input logic rb, input logic exp_rdy);
        d = vd; sel = vs; in_valid = vv; qa_ready = ra; qb_ready = rb;
        #1;
        chk("in_ready", W'(in_ready), W'(exp_rdy));
        @(posedge clk);
        if (vv && exp_rdy) begin
            if (vs) exp_b.push_back(vd);
            else exp_a.push_back(vd);
        end
        #2;
    endtask

    task automatic do_reset(input logic [W-1:0] vd, input logic vs, input logic vv);
        rst_n = 1'b0; d = vd; sel = vs; in_valid = vv; qa_ready = 1'b1; qb_ready = 1'b1;
        @(posedge clk);
        exp_a.delete();
        exp_b.delete();
`ifdef DEMUX_BUF_COUNT_EN
        exp_cnt_a = '0;
        exp_cnt_b = '0;
`endif
        #2;
        rst_n = 1'b1; in_valid = 1'b0; qa_ready = 1'b0; qb_ready = 1'b0;
        #1;
        chk("rst_qa_valid", W'(qa_valid), '0);
        chk("rst_qb_valid", W'(qb_valid), '0);
        chk("rst_qa", qa, '0);
        chk("rst_qb", qb, '0);
        chk("rst_in_ready", W'(in_ready), W'(1));
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #2;
        do_reset('0, 1'b0, 1'b0);

        // First word after reset lands on channel a.
        step(1, 0, 1, 1, 0, 1);
        step(0, 0, 0, 1, 0, 1);

        // Back-pressure on channel a.
        step(3, 0, 1, 0, 0, 1);
        step(5, 0, 1, 0, 0, 0);
        chk("qa_held", qa, 3);
        step(5, 0, 1, 1, 0, 1);

        // Channel b proceeds while a is stalled.
        step(4, 1, 1, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0);
        chk("qa_stalled", qa, 5);
        chk("qb_loaded", qb, 4);

        // Drain and load on b in the same cycle, then both channels drain.
        step(6, 1, 1, 0, 1, 1);
        step(8, 1, 1, 0, 1, 1);
        step(9, 1, 1, 1, 1, 1);

        // in_valid low changes nothing; qa keeps its stale value while empty.
        step(11, 0, 0, 0, 0, 1);
        chk("qa_stale", qa, 5);
        chk("qb_hold9", qb, 9);

        // Fill both slots with 7 and 10, then reset with a transfer pending.
        step(7, 0, 1, 0, 0, 1);
        step(10, 1, 1, 0, 1, 1);
        step(0, 0, 0, 0, 0, 0);
        chk("qa_pre_rst", qa, 7);
        chk("qb_pre_rst", qb, 10);
        do_reset(12, 0, 1);

        step(13, 1, 1, 1, 1, 1);
        step(0, 0, 0, 1, 1, 1);

        // Five deliveries on channel a from a clean reset.
        do_reset('0, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) step(W'(20 + k), 0, 1, 1, 0, 1);
        step(0, 0, 0, 1, 0, 1);
        @(negedge clk);
        #1;
        chk("a_drained", W'(qa_valid), '0);
`ifdef DEMUX_BUF_COUNT_EN
        chk("cnt_a_wrap", W'(cnt_a), W'(1));
        chk("cnt_b_zero", W'(cnt_b), '0);
`endif
        chk("queues_empty", W'(exp_a.size() + exp_b.size()), '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
